vc_credit_sender: RTL and testbench

VC_CREDIT_SENDER -- requirements
Module: vc_credit_sender

---
 rtl/vc_credit_sender.sv | 95 +++++++++
 tb/tb_vc_credit_sender.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vc_credit_sender.sv
// vc_credit_sender
//
// Credit-based sender for one virtual channel of a link. The sender starts
// with p_num_credits credits, one per slot of the downstream receive queue.
// It spends one credit per message sent and regains one each time the
// downstream queue frees a slot (credit_ret). The link itself has no
// back-pressure, so a message is only accepted when a credit is in hand.
//
// Handshake: a message transfers on the enq side in any cycle where
// enq_val && enq_rdy are both high at posedge clk. enq_rdy never looks at
// enq_val. The producer must hold enq_msg stable while enq_val is high and
// enq_rdy is low. The link side is valid-only: send_val/send_msg are
// registered and appear exactly one cycle after the transfer.
//
// Configuration macro: VC_CREDIT_SENDER_BYPASS_EN
//   undefined (default): a returned credit can be spent from the next cycle.
//   defined: a credit arriving while the counter is at zero can be spent in
//            the same cycle (enq_rdy also rises on credit_ret).
//
// Ports
//   clk          in   clock, all state updates on posedge
//   reset        in   synchronous, active-low reset
//   enq_val      in   producer message valid
//   enq_rdy      out  sender accepts a message this cycle (0 during reset)
//   enq_msg      in   producer message [p_msg_nbits]
//   send_val     out  registered, message on link this cycle
//   send_msg     out  registered link message [p_msg_nbits], holds when idle
//   credit_ret   in   one credit returned by the downstream queue
//   num_credits  out  credits currently available [c_cnt_nbits]
//   err_overflow out  sticky, a credit came back with the counter already full

module vc_credit_sender #(
    parameter int p_msg_nbits   = 8,
    parameter int p_num_credits = 2,
    localparam int c_cnt_nbits  = $clog2(p_num_credits + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val,
    output logic                   enq_rdy,
    input  logic [p_msg_nbits-1:0] enq_msg,
    output logic                   send_val,
    output logic [p_msg_nbits-1:0] send_msg,
    input  logic                   credit_ret,
    output logic [c_cnt_nbits-1:0] num_credits,
    output logic                   err_overflow
);

    localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_num_credits);
    localparam logic [c_cnt_nbits-1:0] c_one = c_cnt_nbits'(1);

    logic do_enq;

    // Gated by reset so the producer never sees a transfer while the
    // sender is being cleared.
    always_comb begin
        enq_rdy = 1'b0;
`ifdef VC_CREDIT_SENDER_BYPASS_EN
        enq_rdy = reset && ((num_credits != '0) || credit_ret);
`else
        enq_rdy = reset && (num_credits != '0);
`endif
        do_enq = enq_val && enq_rdy;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            send_val     <= 1'b0;
            send_msg     <= '0;
            num_credits  <= c_max;
            err_overflow <= 1'b0;
        end else begin
            send_val <= do_enq;
            if (do_enq) begin
                send_msg <= enq_msg;
            end

            // Spend and return in the same cycle cancel out. With bypass
            // this also covers the zero-credit case: the returning credit is
            // spent immediately and the counter stays at zero.
            if (do_enq && !credit_ret) begin
                num_credits <= num_credits - c_one;
            end else if (!do_enq && credit_ret) begin
                if (num_credits == c_max) begin
                    // Downstream returned more credits than it owns:
                    // saturate and flag it permanently.
                    err_overflow <= 1'b1;
                end else begin
                    num_credits <= num_credits + c_one;
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_credit_sender.sv
// Testbench for vc_credit_sender (p_num_credits=2, p_msg_nbits=8).
// A credit-count model kept as a plain integer, an expected-message queue
// and a sticky error flag predict every output; directed steps cover the
// listed scenarios, followed by a randomized phase with occasional resets.

module tb_vc_credit_sender;

    localparam int MW = 8;
    localparam int NC = 2;
    localparam int CW = $clog2(NC + 1);

    logic          clk;
    logic          reset;
    logic          enq_val;
    logic          enq_rdy;
    logic [MW-1:0] enq_msg;
    logic          send_val;
    logic [MW-1:0] send_msg;
    logic          credit_ret;
    logic [CW-1:0] num_credits;
    logic          err_overflow;

    vc_credit_sender #(.p_msg_nbits(MW), .p_num_credits(NC)) dut (
        .clk          (clk),
        .reset        (reset),
        .enq_val      (enq_val),
        .enq_rdy      (enq_rdy),
        .enq_msg      (enq_msg),
        .send_val     (send_val),
        .send_msg     (send_msg),
        .credit_ret   (credit_ret),
        .num_credits  (num_credits),
        .err_overflow (err_overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model / scoreboard ----------------
    int            m_credits;
    bit            m_err;
    logic [MW-1:0] m_last;
    logic [MW-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit exp_send);
        logic [MW-1:0] e;
        check("send_val", 32'(send_val), 32'(exp_send));
        if (send_val === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("send_order", 32'(send_msg), 32'(e));
        end
        check("send_msg", 32'(send_msg), 32'(m_last));
        check("num_credits", 32'(num_credits), 32'(m_credits));
        check("err_overflow", 32'(err_overflow), 32'(m_err));
    endtask

    // ---------------- drivers ----------------
    // One normal cycle: drive at negedge, check enq_rdy, clock, check outputs.
    task automatic cycle(input bit val, input logic [MW-1:0] msg, input bit cr);
        bit exp_rdy;
        bit do_enq;
        @(negedge clk);
        reset      = 1'b1;
        enq_val    = val;
        enq_msg    = msg;
        credit_ret = cr;
        #1;
`ifdef VC_CREDIT_SENDER_BYPASS_EN
        exp_rdy = (m_credits > 0) || cr;
`else
        exp_rdy = (m_credits > 0);
`endif
        check("enq_rdy", 32'(enq_rdy), 32'(exp_rdy));
        do_enq = val && exp_rdy;
        if (do_enq) exp_q.push_back(msg);
        @(posedge clk);
        #1;
        m_credits = m_credits - int'(do_enq) + int'(cr);
        if (m_credits > NC) begin
            m_credits = NC;
            m_err     = 1'b1;
        end
        if (m_credits < 0) m_credits = 0;
        if (do_enq) m_last = msg;
        check_outputs(do_enq);
    endtask

    // Reset cycles with busy inputs that must be ignored.
    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset      = 1'b0;
            enq_val    = 1'b1;
            enq_msg    = MW'($urandom);
            credit_ret = 1'($urandom_range(0, 1));
            #1;
            check("enq_rdy_in_reset", 32'(enq_rdy), 32'(0));
            @(posedge clk);
            #1;
            m_credits = NC;
            m_err     = 1'b0;
            m_last    = '0;
            exp_q.delete();
            check_outputs(1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        enq_val    = 1'b0;
        enq_msg    = '0;
        credit_ret = 1'b0;
        m_credits  = NC;
        m_err      = 1'b0;
        m_last     = '0;

        // Reset low two cycles, then first cycle checks enq_rdy=1.
        do_reset(2);
        cycle(1'b0, 8'h00, 1'b0);

        // Three back-to-back offers with no credit return: two go out.
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        check("credits_empty", 32'(num_credits), 32'(0));
        cycle(1'b1, 8'hC3, 1'b0);

        // Credit returns while 0xC3 is still offered.
        cycle(1'b1, 8'hC3, 1'b1);
`ifdef VC_CREDIT_SENDER_BYPASS_EN
        check("bypass_send", 32'(send_val), 32'(1));
        check("bypass_credits", 32'(num_credits), 32'(0));
        cycle(1'b0, 8'h00, 1'b0);
`else
        check("no_bypass_hold", 32'(send_val), 32'(0));
        cycle(1'b1, 8'hC3, 1'b0);
        check("late_send", 32'(send_msg), 32'(8'hC3));
`endif

        // Get back to one credit, then spend and return in the same cycle.
        cycle(1'b0, 8'h00, 1'b1);
        check("one_credit", 32'(num_credits), 32'(1));
        cycle(1'b1, 8'h3C, 1'b1);
        check("spend_return_credits", 32'(num_credits), 32'(1));

        // Fill to full, then return one more: overflow, sticky.
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("overflow_set", 32'(err_overflow), 32'(1));
        check("overflow_sat", 32'(num_credits), 32'(NC));
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("overflow_sticky", 32'(err_overflow), 32'(1));

        // Accept 0x55 then reset immediately: the pending state is cleared.
        cycle(1'b1, 8'h55, 1'b0);
        do_reset(1);
        check("reset_mid_sendval", 32'(send_val), 32'(0));
        check("reset_mid_credits", 32'(num_credits), 32'(NC));
        cycle(1'b0, 8'h00, 1'b0);

        // Randomized phase; credit returns only while messages are owed
        // most of the time, with occasional stray returns and resets.
        for (int i = 0; i < 400; i++) begin
            bit cr;
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1);
            end else begin
                cr = (m_credits < NC) ? 1'($urandom_range(0, 2) == 0)
                                      : 1'($urandom_range(0, 19) == 0);
                cycle(1'($urandom_range(0, 1)), MW'($urandom), cr);
            end
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
